// File: rtl/fm_weight_streamer_if.sv
// Output stream of fm_weight_streamer: word, valid/ready handshake and weight tag.
interface fm_weight_streamer_if #(
    parameter int unsigned DW = 8,
    parameter int unsigned CH = 4
);
    logic [CH*DW-1:0] data_o;
    logic             valid_o;
    logic             ready_i;
    logic             weight_ing;

    modport master (
        output data_o,
        output valid_o,
        output weight_ing,
        input  ready_i
    );

    modport slave (
        input  data_o,
        input  valid_o,
        input  weight_ing,
        output ready_i
    );
endinterface

// File: rtl/fm_weight_streamer.sv
// Streams W_WORDS weight words, then BATCHES x FM_PIXELS feature-map words, through a 2-entry skid buffer.
// Define STREAMER_WEIGHT_RELOAD_EN to replay the weight phase before every batch.
module fm_weight_streamer #(
    parameter int unsigned DW        = 8,
    parameter int unsigned CH        = 4,
    parameter int unsigned W_WORDS   = 200,
    parameter int unsigned FM_PIXELS = 12544,
    parameter int unsigned BATCHES   = 8,
    localparam int unsigned WAW = (W_WORDS   > 1) ? $clog2(W_WORDS)   : 1,
    localparam int unsigned PAW = (FM_PIXELS > 1) ? $clog2(FM_PIXELS) : 1,
    localparam int unsigned BAW = (BATCHES   > 1) ? $clog2(BATCHES)   : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic [WAW-1:0]       w_addr,
    input  logic [CH*DW-1:0]     w_rdata,
    output logic [BAW-1:0]       fm_batch,
    output logic [PAW-1:0]       fm_pix,
    input  logic [CH*DW-1:0]     fm_rdata,
    fm_weight_streamer_if.master st,
    output logic                 busy,
    output logic                 done
);
    localparam logic [WAW-1:0] W_LAST = WAW'(W_WORDS - 1);
    localparam logic [PAW-1:0] P_LAST = PAW'(FM_PIXELS - 1);
    localparam logic [BAW-1:0] B_LAST = BAW'(BATCHES - 1);

    typedef enum logic [1:0] {IDLE, WEIGHT, FMAP, DONE} state_t;

    state_t           state_q;
    logic [WAW-1:0]   w_addr_q;
    logic [BAW-1:0]   batch_q;
    logic [PAW-1:0]   pix_q;
    logic             req_q, req_w_q;
    logic             resp_q, resp_w_q;
    logic             issue_done_q;
    logic             busy_q, done_q;

    logic             out_valid_q, out_valid_d;
    logic [CH*DW-1:0] out_data_q, out_data_d;
    logic             out_w_q, out_w_d;
    logic [CH*DW-1:0] sk0_data_q, sk0_data_d, sk1_data_q, sk1_data_d;
    logic             sk0_w_q, sk0_w_d, sk1_w_q, sk1_w_d;
    logic [1:0]       sk_cnt_q, sk_cnt_d;

    logic [CH*DW-1:0] in_data;
    logic             out_free;
    logic [2:0]       occ;
    logic             space;

    // Output register plus skid form a 3-word store; a read is issued only if
    // every word already in flight still has a slot when it lands.
    always_comb begin
        in_data     = resp_w_q ? w_rdata : fm_rdata;
        out_free    = !out_valid_q || st.ready_i;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_w_d     = out_w_q;
        sk0_data_d  = sk0_data_q;
        sk0_w_d     = sk0_w_q;
        sk1_data_d  = sk1_data_q;
        sk1_w_d     = sk1_w_q;
        sk_cnt_d    = sk_cnt_q;

        if (out_free) begin
            if (sk_cnt_q != 2'd0) begin
                out_data_d  = sk0_data_q;
                out_w_d     = sk0_w_q;
                out_valid_d = 1'b1;
                sk0_data_d  = sk1_data_q;
                sk0_w_d     = sk1_w_q;
                sk_cnt_d    = sk_cnt_q - 2'd1;
            end else if (resp_q) begin
                out_data_d  = in_data;
                out_w_d     = resp_w_q;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end

        if (resp_q && (!out_free || sk_cnt_q != 2'd0)) begin
            if (sk_cnt_d == 2'd0) begin
                sk0_data_d = in_data;
                sk0_w_d    = resp_w_q;
            end else begin
                sk1_data_d = in_data;
                sk1_w_d    = resp_w_q;
            end
            sk_cnt_d = sk_cnt_d + 2'd1;
        end

        occ   = 3'(out_valid_d) + 3'(sk_cnt_d) + 3'(req_q);
        space = (occ <= 3'd2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            w_addr_q     <= '0;
            batch_q      <= '0;
            pix_q        <= '0;
            req_q        <= 1'b0;
            req_w_q      <= 1'b0;
            resp_q       <= 1'b0;
            resp_w_q     <= 1'b0;
            issue_done_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_w_q      <= 1'b0;
            sk0_data_q   <= '0;
            sk0_w_q      <= 1'b0;
            sk1_data_q   <= '0;
            sk1_w_q      <= 1'b0;
            sk_cnt_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_w_q     <= out_w_d;
            sk0_data_q  <= sk0_data_d;
            sk0_w_q     <= sk0_w_d;
            sk1_data_q  <= sk1_data_d;
            sk1_w_q     <= sk1_w_d;
            sk_cnt_q    <= sk_cnt_d;
            resp_q      <= req_q;
            resp_w_q    <= req_w_q;
            req_q       <= 1'b0;
            done_q      <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q      <= WEIGHT;
                        busy_q       <= 1'b1;
                        w_addr_q     <= '0;
                        batch_q      <= '0;
                        pix_q        <= '0;
                        issue_done_q <= 1'b0;
                        req_q        <= 1'b1;
                        req_w_q      <= 1'b1;
                    end
                end
                // In WEIGHT the fm counters already name the next pixel to read.
                WEIGHT: begin
                    if (space) begin
                        req_q <= 1'b1;
                        if (w_addr_q == W_LAST) begin
                            state_q <= FMAP;
                            req_w_q <= 1'b0;
                        end else begin
                            w_addr_q <= w_addr_q + WAW'(1);
                            req_w_q  <= 1'b1;
                        end
                    end
                end
                FMAP: begin
                    if (!issue_done_q) begin
                        if (space) begin
                            if (pix_q != P_LAST) begin
                                pix_q   <= pix_q + PAW'(1);
                                req_q   <= 1'b1;
                                req_w_q <= 1'b0;
                            end else if (batch_q == B_LAST) begin
                                issue_done_q <= 1'b1;
                            end else begin
                                pix_q   <= '0;
                                batch_q <= batch_q + BAW'(1);
                                req_q   <= 1'b1;
`ifdef STREAMER_WEIGHT_RELOAD_EN
                                state_q  <= WEIGHT;
                                w_addr_q <= '0;
                                req_w_q  <= 1'b1;
`else
                                req_w_q  <= 1'b0;
`endif
                            end
                        end
                    end else if (!req_q && !resp_q && sk_cnt_q == 2'd0 &&
                                 out_valid_q && st.ready_i) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign w_addr        = w_addr_q;
    assign fm_batch      = batch_q;
    assign fm_pix        = pix_q;
    assign st.data_o     = out_data_q;
    assign st.valid_o    = out_valid_q;
    assign st.weight_ing = out_valid_q && out_w_q;
    assign busy          = busy_q;
    assign done          = done_q;
endmodule

// File: doc/fm_weight_streamer.md
FM_WEIGHT_STREAMER -- requirements
Module: fm_weight_streamer

Interface
REQ-001 SHALL have parameters: DW, default 8, bits per lane.
REQ-002 SHALL have parameter CH, default 4, lanes packed per output word, lane 0 in the MSBs.
REQ-003 SHALL have parameter W_WORDS, default 200, weight words per load.
REQ-004 SHALL have parameter FM_PIXELS, default 12544, pixels per channel group.
REQ-005 SHALL have parameter BATCHES, default 8, channel groups per run.
REQ-006 SHALL have ports: clk  in  1  clock; all logic on its rising edge.
REQ-007 SHALL have port rst  in  1  synchronous active-high reset; the block uses one clock, with reset synchronous and active-high.
REQ-008 SHALL have port start  in  1  one-cycle run request.
REQ-009 SHALL have port w_addr  out  clog2(W_WORDS)  weight memory word address.
REQ-010 SHALL have port w_rdata  in  CH*DW  weight word, valid 1 cycle after address.
REQ-011 SHALL have port fm_batch  out  clog2(BATCHES)  and fm_pix  out  clog2(FM_PIXELS)  feature-map read address.
REQ-012 SHALL have port fm_rdata  in  CH*DW  CH channels of one pixel, valid 1 cycle after address.
REQ-013 SHALL have port data_o  out  CH*DW  streamed word.
REQ-014 SHALL have port valid_o  out  1  and ready_i  in  1  output handshake.
REQ-015 SHALL have port weight_ing  out  1  high while weight words are streamed.
REQ-016 SHALL have port busy  out  1  and done  out  1  one-cycle end-of-run pulse.

Function
REQ-017 SHALL use states IDLE, WEIGHT, FMAP, DONE.
REQ-018 IDLE->WEIGHT on start; start in any other state SHALL be ignored.
REQ-019 WEIGHT SHALL stream words 0..W_WORDS-1 in order, then go to FMAP.
REQ-020 FMAP SHALL stream fm_pix 0..FM_PIXELS-1 per batch; at FM_PIXELS-1 pix wraps to 0 and batch increments.
REQ-021 After batch BATCHES-1, pixel FM_PIXELS-1 is handshaken: DONE for one cycle with done=1, then IDLE.
REQ-022 A transfer SHALL occur only on a cycle with valid_o&&ready_i.
REQ-023 While valid_o&&!ready_i, data_o SHALL hold stable and no word SHALL be dropped or duplicated; a 2-entry skid buffer absorbs the 1-cycle read latency.
REQ-024 valid_o SHALL first assert 2 cycles after start is sampled; with ready_i held high, throughput SHALL be 1 word/cycle with no bubbles, including at the WEIGHT->FMAP and batch boundaries.
REQ-025 weight_ing SHALL be high exactly while the word at the output register is a weight word.
REQ-026 busy SHALL be high from the cycle after start until done is asserted.
REQ-027 Memory addresses SHALL only advance when the skid buffer has space; no read is issued in IDLE.

Reset
REQ-028 rst SHALL force state IDLE, valid_o=0, done=0, busy=0, weight_ing=0, all counters and addresses 0, data_o=0, and flush the skid buffer.
REQ-029 rst asserted mid-run SHALL abort the run; no done is produced, and a new start is required.

Configuration
REQ-030 With STREAMER_WEIGHT_RELOAD_EN defined, the block SHALL replay the full WEIGHT phase before every batch, giving BATCHES*(W_WORDS+FM_PIXELS) words per run; otherwise weights are streamed once, giving W_WORDS+BATCHES*FM_PIXELS words.

Verification
REQ-031 W_WORDS=4, FM_PIXELS=6, BATCHES=2, ready_i=1, start pulse -> 16 words; weight_ing high for the first 4; done 1 cycle after the 16th handshake.
REQ-032 Same parameters, ready_i toggling every cycle -> identical 16-word sequence; data_o stable in every stalled cycle.
REQ-033 STREAMER_WEIGHT_RELOAD_EN defined, same parameters -> 20 words: 4 W, 6 FM(b0), 4 W, 6 FM(b1).
REQ-034 rst asserted at word 7 -> valid_o=0 the next cycle, no done; a fresh start replays from weight word 0.
REQ-035 start re-pulsed while busy -> ignored; the word count and order are unchanged.
REQ-036 ready_i=0 held 5 cycles at the WEIGHT->FMAP boundary -> after release, weight word 3 is followed directly by fm(b0,p0) with no loss.
